// File: rtl/ram_rmw_ctrl.sv
// Read-modify-write controller for a saturating 4-bit counter RAM.
// Issues a read, computes the new value, writes it back only when it changed.
module ram_rmw_ctrl #(
  parameter int DEPTH   = 1070,
  parameter int TIMEOUT = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [10:0] req_addr,
  input  logic [1:0]  req_op,
  input  logic [3:0]  req_data,
  output logic        ram_en,
  output logic        ram_we,
  output logic [10:0] ram_addr,
  output logic [3:0]  ram_di,
  input  logic [3:0]  ram_do,
  input  logic        ram_do_valid,
  output logic        rsp_valid,
  output logic [3:0]  rsp_data,
  output logic [10:0] rsp_addr,
  output logic        rsp_err
);

  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT, RESP} state_t;

  localparam int              CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [11:0]     DEPTH_L  = 12'(DEPTH);

  state_t        state_reg, state_next;
  logic [10:0]   addr_reg, addr_next;
  logic [1:0]    op_reg, op_next;
  logic [3:0]    data_reg, data_next;
  logic [3:0]    old_reg, old_next;
  logic [3:0]    new_reg, new_next;
  logic          err_reg, err_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  // Holds req_ready low until the first clock edge after reset is released.
  logic          rdy_reg;
  logic [3:0]    calc_val;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      op_reg    <= '0;
      data_reg  <= '0;
      old_reg   <= '0;
      new_reg   <= '0;
      err_reg   <= 1'b0;
      cnt_reg   <= '0;
      rdy_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      op_reg    <= op_next;
      data_reg  <= data_next;
      old_reg   <= old_next;
      new_reg   <= new_next;
      err_reg   <= err_next;
      cnt_reg   <= cnt_next;
      rdy_reg   <= 1'b1;
    end
  end

  always_comb begin
    calc_val = ram_do;
    case (op_reg)
      2'b00:   calc_val = (ram_do == 4'hF) ? ram_do : ram_do + 4'd1;
      2'b01:   calc_val = (ram_do == 4'h0) ? ram_do : ram_do - 4'd1;
      2'b10:   calc_val = data_reg;
      default: calc_val = ram_do;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    op_next    = op_reg;
    data_next  = data_reg;
    old_next   = old_reg;
    new_next   = new_reg;
    err_next   = err_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid && rdy_reg) begin
          addr_next = req_addr;
          op_next   = req_op;
          data_next = req_data;
          old_next  = '0;
          new_next  = '0;
          cnt_next  = '0;
          if ({1'b0, req_addr} < DEPTH_L) begin
            err_next   = 1'b0;
            state_next = RD_ISSUE;
          end else begin
            err_next   = 1'b1;
            state_next = RESP;
          end
        end
      end
      RD_ISSUE: begin
        cnt_next   = '0;
        state_next = RD_WAIT;
      end
      RD_WAIT: begin
        if (ram_do_valid) begin
          old_next = ram_do;
          new_next = calc_val;
          state_next = (op_reg == 2'b11 || calc_val == ram_do) ? RESP : WR_ISSUE;
        end else if (cnt_reg == CNT_LAST) begin
          err_next   = 1'b1;
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      WR_ISSUE: begin
        cnt_next   = '0;
        state_next = WR_WAIT;
      end
      WR_WAIT: begin
        if (ram_do_valid) begin
          state_next = RESP;
        end else if (cnt_reg == CNT_LAST) begin
          err_next   = 1'b1;
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign req_ready = (state_reg == IDLE) && rdy_reg;
  assign ram_en    = (state_reg == RD_ISSUE) || (state_reg == WR_ISSUE);
  assign ram_we    = (state_reg == WR_ISSUE);
  assign ram_di    = (state_reg == WR_ISSUE) ? new_reg : 4'd0;
  assign ram_addr  = (state_reg == IDLE) ? 11'd0 : addr_reg;
  assign rsp_valid = (state_reg == RESP);
  assign rsp_err   = (state_reg == RESP) && err_reg;
  assign rsp_data  = (state_reg == RESP) ? old_reg : 4'd0;
  assign rsp_addr  = (state_reg == RESP) ? addr_reg : 11'd0;

endmodule

// File: tb/tb_ram_rmw_ctrl.sv
// Directed bench for ram_rmw_ctrl with a fixed 3-cycle RAM responder stub.
module tb_ram_rmw_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [10:0] req_addr;
  logic [1:0]  req_op;
  logic [3:0]  req_data;
  logic        ram_en, ram_we;
  logic [10:0] ram_addr;
  logic [3:0]  ram_di, ram_do;
  logic        ram_do_valid;
  logic        rsp_valid, rsp_err;
  logic [3:0]  rsp_data;
  logic [10:0] rsp_addr;

  int total = 0;
  int bad   = 0;

  logic [3:0] mem [0:2047];
  logic       mute;
  logic       stray;
  logic       stub_clr;
  logic [2:0] v_pipe;
  logic [3:0] d_p0, d_p1, d_p2;

  always #5 clk = ~clk;

  ram_rmw_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_op(req_op), .req_data(req_data),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di),
    .ram_do(ram_do), .ram_do_valid(ram_do_valid),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_addr(rsp_addr), .rsp_err(rsp_err)
  );

  // Responder: data/valid three cycles after the command strobe.
  always @(posedge clk) begin
    if (stub_clr) begin
      v_pipe <= '0;
      mem[5] = 4'd3;
      mem[7] = 4'd15;
      mem[8] = 4'd0;
      mem[1069] = 4'd2;
    end else begin
      v_pipe <= {v_pipe[1:0], ram_en & ~mute};
    end
    d_p0 <= mem[ram_addr];
    d_p1 <= d_p0;
    d_p2 <= d_p1;
    if (ram_en && ram_we) mem[ram_addr] = ram_di;
  end
  assign ram_do       = d_p2;
  assign ram_do_valid = v_pipe[2] | stray;

  task automatic do_req(input logic [10:0] a, input logic [1:0] op, input logic [3:0] d,
                        output int rcyc, output logic [3:0] rdata, output logic rerr,
                        output logic [10:0] raddr, output int en_n, output int wr_n,
                        output logic [3:0] di, output logic addr_ok, output int rdy_cyc);
    rcyc = -1; rdata = 'x; rerr = 'x; raddr = 'x; en_n = 0; wr_n = 0; di = 'x;
    addr_ok = 1'b1; rdy_cyc = -1;
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_op = op; req_data = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (ram_en) en_n++;
      if (ram_en && ram_we) begin wr_n++; di = ram_di; end
      if (rcyc < 0 && ram_addr !== a) addr_ok = 1'b0;
      if (rsp_valid && rcyc < 0) begin
        rcyc = cyc; rdata = rsp_data; rerr = rsp_err; raddr = rsp_addr;
      end else if (rcyc >= 0 && req_ready) begin
        rdy_cyc = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_op = '0; req_data = '0;
    mute = 1'b0; stray = 1'b0; stub_clr = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({req_ready, ram_en, ram_we, rsp_valid, rsp_err} !== 5'b0 || ram_addr !== 11'd0 ||
        rsp_data !== 4'd0 || rsp_addr !== 11'd0) begin
      bad++;
      $display("FAIL reset_outputs: got rdy=%b en=%b we=%b rv=%b err=%b ra=%0d rd=%0d rsa=%0d, want all 0",
               req_ready, ram_en, ram_we, rsp_valid, rsp_err, ram_addr, rsp_data, rsp_addr);
    end
    stub_clr = 1'b0;
    rst_n = 1'b1;
    #1;
    total++;
    if (req_ready !== 1'b0) begin
      bad++; $display("FAIL reset_release_ready: got %b want 0", req_ready);
    end
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready_after: got %b want 1", req_ready);
    end
    $display("reset: ready=%b", req_ready);
  endtask

  task automatic test_increment();
    int rc, en, wr, rdy; logic [3:0] rd, di; logic er, aok; logic [10:0] ra;
    do_req(11'd5, 2'b00, 4'd0, rc, rd, er, ra, en, wr, di, aok, rdy);
    $display("inc a=5: rsp@%0d data=%0d err=%b wr=%0d di=%0d rdy@%0d", rc, rd, er, wr, di, rdy);
    total++;
    if (rc !== 9 || rd !== 4'd3 || er !== 1'b0 || ra !== 11'd5) begin
      bad++; $display("FAIL inc_rsp: got cyc=%0d data=%0d err=%b addr=%0d want 9/3/0/5", rc, rd, er, ra);
    end
    total++;
    if (wr !== 1 || di !== 4'd4 || en !== 2 || mem[5] !== 4'd4) begin
      bad++; $display("FAIL inc_write: got wr=%0d di=%0d en=%0d mem=%0d want 1/4/2/4", wr, di, en, mem[5]);
    end
    total++;
    if (rdy !== 10 || aok !== 1'b1) begin
      bad++; $display("FAIL inc_ready_addr: got rdy=%0d addr_ok=%b want 10/1", rdy, aok);
    end
  endtask

  task automatic test_decrement();
    int rc, en, wr, rdy; logic [3:0] rd, di; logic er, aok; logic [10:0] ra;
    do_req(11'd5, 2'b01, 4'd0, rc, rd, er, ra, en, wr, di, aok, rdy);
    $display("dec a=5: rsp@%0d data=%0d err=%b wr=%0d di=%0d", rc, rd, er, wr, di);
    total++;
    if (rc !== 9 || rd !== 4'd4 || er !== 1'b0 || wr !== 1 || di !== 4'd3) begin
      bad++; $display("FAIL dec: got cyc=%0d data=%0d err=%b wr=%0d di=%0d want 9/4/0/1/3", rc, rd, er, wr, di);
    end
  endtask

  task automatic test_saturation();
    int rc, en, wr, rdy; logic [3:0] rd, di; logic er, aok; logic [10:0] ra;
    do_req(11'd7, 2'b00, 4'd0, rc, rd, er, ra, en, wr, di, aok, rdy);
    $display("sat_inc a=7: rsp@%0d data=%0d err=%b wr=%0d en=%0d", rc, rd, er, wr, en);
    total++;
    if (rc !== 5 || rd !== 4'd15 || er !== 1'b0 || wr !== 0 || en !== 1 || rdy !== 6) begin
      bad++; $display("FAIL sat_inc: got cyc=%0d data=%0d err=%b wr=%0d en=%0d rdy=%0d want 5/15/0/0/1/6", rc, rd, er, wr, en, rdy);
    end
    do_req(11'd8, 2'b01, 4'd0, rc, rd, er, ra, en, wr, di, aok, rdy);
    $display("sat_dec a=8: rsp@%0d data=%0d err=%b wr=%0d en=%0d", rc, rd, er, wr, en);
    total++;
    if (rc !== 5 || rd !== 4'd0 || er !== 1'b0 || wr !== 0 || en !== 1) begin
      bad++; $display("FAIL sat_dec: got cyc=%0d data=%0d err=%b wr=%0d en=%0d want 5/0/0/0/1", rc, rd, er, wr, en);
    end
  endtask

  task automatic test_write_read();
    int rc, en, wr, rdy; logic [3:0] rd, di; logic er, aok; logic [10:0] ra;
    do_req(11'd1069, 2'b10, 4'd9, rc, rd, er, ra, en, wr, di, aok, rdy);
    $display("write a=1069 d=9: rsp@%0d data=%0d err=%b wr=%0d di=%0d", rc, rd, er, wr, di);
    total++;
    if (rc !== 9 || rd !== 4'd2 || er !== 1'b0 || wr !== 1 || di !== 4'd9 || ra !== 11'd1069) begin
      bad++; $display("FAIL write: got cyc=%0d data=%0d err=%b wr=%0d di=%0d addr=%0d want 9/2/0/1/9/1069", rc, rd, er, wr, di, ra);
    end
    do_req(11'd1069, 2'b11, 4'd0, rc, rd, er, ra, en, wr, di, aok, rdy);
    $display("read a=1069: rsp@%0d data=%0d err=%b wr=%0d", rc, rd, er, wr);
    total++;
    if (rc !== 5 || rd !== 4'd9 || er !== 1'b0 || wr !== 0 || aok !== 1'b1) begin
      bad++; $display("FAIL read: got cyc=%0d data=%0d err=%b wr=%0d aok=%b want 5/9/0/0/1", rc, rd, er, wr, aok);
    end
  endtask

  task automatic test_illegal();
    int rc, en, wr, rdy; logic [3:0] rd, di; logic er, aok; logic [10:0] ra;
    do_req(11'd1070, 2'b00, 4'd0, rc, rd, er, ra, en, wr, di, aok, rdy);
    $display("illegal a=1070: rsp@%0d data=%0d err=%b en=%0d", rc, rd, er, en);
    total++;
    if (rc !== 1 || rd !== 4'd0 || er !== 1'b1 || en !== 0 || ra !== 11'd1070 || rdy !== 2) begin
      bad++; $display("FAIL illegal_1070: got cyc=%0d data=%0d err=%b en=%0d addr=%0d rdy=%0d want 1/0/1/0/1070/2", rc, rd, er, en, ra, rdy);
    end
    do_req(11'd2047, 2'b10, 4'd5, rc, rd, er, ra, en, wr, di, aok, rdy);
    $display("illegal a=2047: rsp@%0d err=%b en=%0d", rc, er, en);
    total++;
    if (rc !== 1 || er !== 1'b1 || en !== 0) begin
      bad++; $display("FAIL illegal_2047: got cyc=%0d err=%b en=%0d want 1/1/0", rc, er, en);
    end
  endtask

  task automatic test_timeout();
    int rc, en, wr, rdy; logic [3:0] rd, di; logic er, aok; logic [10:0] ra;
    mute = 1'b1;
    do_req(11'd5, 2'b11, 4'd0, rc, rd, er, ra, en, wr, di, aok, rdy);
    mute = 1'b0;
    $display("timeout a=5: rsp@%0d data=%0d err=%b en=%0d rdy@%0d", rc, rd, er, en, rdy);
    total++;
    if (rc !== 9 || er !== 1'b1 || rd !== 4'd0 || en !== 1 || rdy !== 10) begin
      bad++; $display("FAIL timeout: got cyc=%0d err=%b data=%0d en=%0d rdy=%0d want 9/1/0/1/10", rc, er, rd, en, rdy);
    end
    @(negedge clk);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    total++;
    if (req_ready !== 1'b1 || ram_en !== 1'b0 || rsp_valid !== 1'b0 || ram_addr !== 11'd0) begin
      bad++; $display("FAIL stray_idle: got rdy=%b en=%b rv=%b ra=%0d want 1/0/0/0", req_ready, ram_en, rsp_valid, ram_addr);
    end
    $display("stray valid in idle: rdy=%b rv=%b", req_ready, rsp_valid);
  endtask

  task automatic test_reset_mid();
    int seen_rsp = 0, seen_en = 0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 11'd5; req_op = 2'b00;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (rsp_valid) seen_rsp++;
      if (ram_en) seen_en++;
    end
    $display("reset mid-txn: rsp=%0d en=%0d mem5=%0d rdy=%b", seen_rsp, seen_en, mem[5], req_ready);
    total++;
    if (seen_rsp !== 0 || seen_en !== 0 || mem[5] !== 4'd3 || req_ready !== 1'b1) begin
      bad++; $display("FAIL reset_mid: got rsp=%0d en=%0d mem=%0d rdy=%b want 0/0/3/1", seen_rsp, seen_en, mem[5], req_ready);
    end
  endtask

  task automatic test_back_to_back();
    int rsp1 = -1, rsp2 = -1, rdy2 = -1, early = 0, addr_bad = 0;
    logic got2 = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 11'd7; req_op = 2'b11;
    @(posedge clk);
    #1 req_addr = 11'd1069;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      if (rsp_valid && rsp1 < 0) rsp1 = cyc;
      else if (rsp_valid && rsp2 < 0) rsp2 = cyc;
      if (cyc <= 5 && ram_addr !== 11'd7) addr_bad++;
      if (cyc >= 7 && cyc <= 11 && ram_addr !== 11'd1069) addr_bad++;
      if (req_ready && !got2) begin
        if (rsp1 < 0) early++;
        got2 = 1'b1; rdy2 = cyc;
        @(posedge clk);
        #1 req_valid = 1'b0;
      end
      if (rsp2 >= 0) break;
    end
    req_valid = 1'b0;
    $display("back-to-back: rsp1@%0d rdy2@%0d rsp2@%0d addr_bad=%0d", rsp1, rdy2, rsp2, addr_bad);
    total++;
    if (rsp1 !== 5 || rdy2 !== 6 || rsp2 !== 11 || early !== 0) begin
      bad++; $display("FAIL b2b_timing: got rsp1=%0d rdy2=%0d rsp2=%0d early=%0d want 5/6/11/0", rsp1, rdy2, rsp2, early);
    end
    total++;
    if (addr_bad !== 0) begin
      bad++; $display("FAIL b2b_addr_stable: got %0d unstable cycles want 0", addr_bad);
    end
  endtask

  initial begin
    test_reset();
    test_increment();
    test_decrement();
    test_saturation();
    test_write_read();
    test_illegal();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
